// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the bring-up execution controller: FSM encoding and
// the default button timing table shared with the debouncers.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHeld   = 2'd1,
        StRepeat = 2'd2
    } step_state_e;

    localparam int unsigned HOLD_CYCLES_DEFAULT   = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEFAULT = 10_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector on a debounced level. The history register loads the
// live level even while in reset, so a level held through reset gives no edge.
module edge_rise (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lvl,
    output logic o_rise
);

    logic r_prev;

    // Level history; reset deliberately loads the current level rather than 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= i_lvl;
        end else begin
            r_prev <= i_lvl;
        end
    end

    assign o_rise = ~i_rst & i_lvl & ~r_prev;

endmodule

// File: rtl/step_ctrl.sv
// Processor execution control for FPGA bring-up: RUN/STEP mode toggle,
// single-step clock-enable pulses and a step counter for the display.
// Optional auto-repeat while the step button is held: STEP_AUTOREPEAT_EN.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = 26,
    parameter int unsigned STEP_CNT_W    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_step_btn,
    input  logic                  i_mode_btn,
    input  logic                  i_halt,
    output logic                  o_cpu_en,
    output logic                  o_step_pulse,
    output logic                  o_run_mode,
    output logic [STEP_CNT_W-1:0] o_step_count
);

`ifdef STEP_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`else
    // Without auto-repeat the timer only measures hold time; saturate so it never wraps.
    localparam logic [CNT_W-1:0] TIMER_SAT = CNT_W'(max_u(HOLD_CYCLES, REPEAT_CYCLES) - 1);
`endif

    step_state_e             r_state, w_state_next;
    logic [CNT_W-1:0]        r_timer, w_timer_next;
    logic                    r_run_mode, w_run_mode_next;
    logic                    r_step_pulse, w_step_pulse_next;
    logic                    r_cpu_en;
    logic [STEP_CNT_W-1:0]   r_step_count;
    logic                    w_step_rise;
    logic                    w_mode_rise;

    edge_rise u_step_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_lvl  (i_step_btn),
        .o_rise (w_step_rise)
    );

    edge_rise u_mode_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_lvl  (i_mode_btn),
        .o_rise (w_mode_rise)
    );

    // Next-state: mode toggle with halt priority, step FSM and hold timer.
    always_comb begin
        w_run_mode_next   = r_run_mode;
        w_state_next      = r_state;
        w_timer_next      = r_timer;
        w_step_pulse_next = 1'b0;

        if (i_halt) begin
            w_run_mode_next = 1'b0;
        end else if (w_mode_rise) begin
            w_run_mode_next = ~r_run_mode;
        end

        case (r_state)
            StIdle: begin
                w_timer_next = '0;
                // Acceptance uses the pre-toggle mode.
                if (w_step_rise && !r_run_mode) begin
                    w_step_pulse_next = 1'b1;
                    w_state_next      = StHeld;
                end
            end
            StHeld: begin
`ifdef STEP_AUTOREPEAT_EN
                if (!i_step_btn || w_run_mode_next || i_halt) begin
                    w_state_next = StIdle;
                    w_timer_next = '0;
                end else if (r_timer == HOLD_LAST) begin
                    w_step_pulse_next = 1'b1;
                    w_state_next      = StRepeat;
                    w_timer_next      = '0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
`else
                if (!i_step_btn) begin
                    w_state_next = StIdle;
                    w_timer_next = '0;
                end else if (r_timer != TIMER_SAT) begin
                    w_timer_next = r_timer + 1'b1;
                end
`endif
            end
            StRepeat: begin
`ifdef STEP_AUTOREPEAT_EN
                if (!i_step_btn || w_run_mode_next || i_halt) begin
                    w_state_next = StIdle;
                    w_timer_next = '0;
                end else if (r_timer == REPEAT_LAST) begin
                    w_step_pulse_next = 1'b1;
                    w_timer_next      = '0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
`else
                w_state_next = StIdle;
                w_timer_next = '0;
`endif
            end
            default: begin
                w_state_next = StIdle;
                w_timer_next = '0;
            end
        endcase
    end

    // State and output registers; cpu_en is built from next values so it lines up with them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_timer      <= '0;
            r_run_mode   <= 1'b0;
            r_step_pulse <= 1'b0;
            r_cpu_en     <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_run_mode   <= w_run_mode_next;
            r_step_pulse <= w_step_pulse_next;
            r_cpu_en     <= w_run_mode_next | w_step_pulse_next;
            r_step_count <= r_step_count + {{(STEP_CNT_W-1){1'b0}}, r_step_pulse};
        end
    end

    assign o_cpu_en     = r_cpu_en;
    assign o_step_pulse = r_step_pulse;
    assign o_run_mode   = r_run_mode;
    assign o_step_count = r_step_count;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with HOLD_CYCLES=8, REPEAT_CYCLES=4. The step
// counter is narrowed to 12 bits so the wrap case stays short.
module tb_step_ctrl;

    localparam int unsigned STEP_W = 12;
`ifdef STEP_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              step_btn;
    logic              mode_btn;
    logic              halt;
    logic              cpu_en;
    logic              step_pulse;
    logic              run_mode;
    logic [STEP_W-1:0] step_count;

    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;
    int unsigned exp_count    = 0;

    step_ctrl #(
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .CNT_W         (26),
        .STEP_CNT_W    (STEP_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_step_btn   (step_btn),
        .i_mode_btn   (mode_btn),
        .i_halt       (halt),
        .o_cpu_en     (cpu_en),
        .o_step_pulse (step_pulse),
        .o_run_mode   (run_mode),
        .o_step_count (step_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, want finish before 2ms");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are then settled and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_release();
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; step_btn = 1'b0; mode_btn = 1'b0; halt = 1'b0;
        tick();
        tick();
        check_eq("rst_cpu_en", 32'(cpu_en), 0);
        check_eq("rst_pulse", 32'(step_pulse), 0);
        check_eq("rst_run", 32'(run_mode), 0);
        check_eq("rst_count", 32'(step_count), 0);
        rst = 1'b0;
        tick();

        // Single press held for 3 cycles.
        step_btn = 1'b1;
        tick();
        check_eq("press_pulse", 32'(step_pulse), 1);
        check_eq("press_cpu_en", 32'(cpu_en), 1);
        check_eq("press_count_lag", 32'(step_count), 0);
        tick();
        check_eq("press_pulse_off", 32'(step_pulse), 0);
        check_eq("press_cpu_en_off", 32'(cpu_en), 0);
        check_eq("press_count", 32'(step_count), 1);
        tick();
        check_eq("press_held3", 32'(step_pulse), 0);
        step_btn = 1'b0;
        tick();
        tick();
        exp_count = 1;

        // Button held through reset release gives no pulse.
        rst = 1'b1; step_btn = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_count = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq($sformatf("thru_rst_pulse%0d", i), 32'(step_pulse), 0);
        end
        check_eq("thru_rst_count", 32'(step_count), exp_count);
        step_btn = 1'b0;
        tick();
        press_release();
        exp_count = 1;
        check_eq("after_rst_count", 32'(step_count), exp_count);

        // RUN mode: continuous cpu_en, step ignored.
        mode_btn = 1'b1;
        tick();
        check_eq("mode_run", 32'(run_mode), 1);
        check_eq("mode_cpu_en", 32'(cpu_en), 1);
        mode_btn = 1'b0;
        tick();
        check_eq("run_cpu_en_hold", 32'(cpu_en), 1);
        step_btn = 1'b1;
        tick();
        check_eq("run_step_pulse", 32'(step_pulse), 0);
        check_eq("run_step_cpu_en", 32'(cpu_en), 1);
        step_btn = 1'b0;
        tick();
        tick();
        check_eq("run_step_count", 32'(step_count), exp_count);

        // Halt beats a same-cycle mode rise.
        halt = 1'b1; mode_btn = 1'b1;
        tick();
        check_eq("halt_run", 32'(run_mode), 0);
        check_eq("halt_cpu_en", 32'(cpu_en), 0);
        halt = 1'b0; mode_btn = 1'b0;
        tick();
        check_eq("halt_run_after", 32'(run_mode), 0);

        // Same-cycle mode and step rise from STEP: toggle applies, step accepted.
        mode_btn = 1'b1; step_btn = 1'b1;
        tick();
        check_eq("both_run", 32'(run_mode), 1);
        check_eq("both_pulse", 32'(step_pulse), 1);
        mode_btn = 1'b0; step_btn = 1'b0;
        tick();
        exp_count++;
        check_eq("both_count", 32'(step_count), exp_count);
        mode_btn = 1'b1;
        tick();
        check_eq("toggle_back", 32'(run_mode), 0);
        mode_btn = 1'b0;
        tick();
        check_eq("toggle_back_cpu_en", 32'(cpu_en), 0);

        // Long hold: 20 cycles.
        step_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_eq($sformatf("hold_off%0d", i), 32'(step_pulse),
                     32'((i == 1) || (AUTOREP && (i == 9 || i == 13 || i == 17))));
        end
        step_btn = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_eq($sformatf("release_off%0d", i), 32'(step_pulse), 0);
        end
        exp_count += AUTOREP ? 4 : 1;
        check_eq("hold_count", 32'(step_count), exp_count);

        // Counter wrap.
        while (exp_count != (1 << STEP_W) - 1) begin
            press_release();
            exp_count++;
        end
        check_eq("count_max", 32'(step_count), exp_count);
        press_release();
        exp_count = 0;
        check_eq("count_wrap", 32'(step_count), exp_count);

        // Reset in the middle of a long hold.
        step_btn = 1'b1;
        repeat (12) tick();
        rst = 1'b1;
        tick();
        check_eq("midrst_cpu_en", 32'(cpu_en), 0);
        check_eq("midrst_pulse", 32'(step_pulse), 0);
        check_eq("midrst_run", 32'(run_mode), 0);
        check_eq("midrst_count", 32'(step_count), 0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("midrst_held%0d", i), 32'(step_pulse), 0);
        end
        check_eq("midrst_count_after", 32'(step_count), 0);
        step_btn = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Consumes the debounced button levels and turns them into processor execution control for FPGA bring-up.
- Turns a debounced "step" level into exactly one single-cycle CPU clock-enable pulse per press.
- Turns a debounced "mode" level into a RUN/STEP toggle.
- Counts issued steps for the display logic.
- Sits between the button debouncers and the pipeline's global stall/enable input.

Parameters:
- HOLD_CYCLES, 50_000_000, cycles the step button must stay held before auto-repeat begins (feature-gated).
- REPEAT_CYCLES, 10_000_000, cycles between auto-repeat pulses while held (feature-gated).
- CNT_W, 26, width of the internal hold/repeat timer; must hold max(HOLD_CYCLES, REPEAT_CYCLES).
- STEP_CNT_W, 16, width of the step counter output.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- step_btn  in  1  debounced step button level, active-high
- mode_btn  in  1  debounced mode button level, active-high
- halt  in  1  processor halt request (e.g. break/syscall); forces STEP mode
- cpu_en  out  1  pipeline clock-enable (advance one cycle when high)
- step_pulse  out  1  one-cycle pulse per accepted step
- run_mode  out  1  1 = RUN, 0 = STEP
- step_count  out  STEP_CNT_W  number of step pulses issued, wraps modulo 2^STEP_CNT_W

Behaviour:
- Clocking: single clock domain on clk. Reset is synchronous and active-high; all state updates on the posedge of clk.
- Reset values: cpu_en=0, step_pulse=0, run_mode=0, step_count=0, FSM=IDLE, timer=0.
- Reset edge-history loading: during reset, the edge-history registers load the current step_btn/mode_btn values, not 0. A button held through reset therefore produces no pulse on release of rst.
- Rising-edge detect: prev register per input; rise = btn & ~prev. The rise is registered, so step_pulse goes high exactly 1 cycle after the first cycle step_btn is seen high, and stays high for exactly 1 cycle.
- FSM states:
  - IDLE: on step rise, go to HELD and emit step_pulse.
  - HELD: timer counts while step_btn is high; step_btn low returns to IDLE.
  - REPEAT: only reachable with the optional feature.
- Mode toggle: a rise on mode_btn inverts run_mode on the next cycle.
- Halt priority: while halt=1, run_mode is forced to 0. Halt beats a same-cycle mode rise.
- Step in RUN mode: step rises are ignored; no step_pulse is emitted and the FSM stays in IDLE.
- Mode change mid-press: a mode rise in the same cycle as a step rise applies the toggle. The step rise is accepted only if the pre-toggle run_mode was 0.
- cpu_en: registered, cpu_en = run_mode | step_pulse. In RUN mode it is continuously 1; in STEP mode it is 1 for exactly one cycle per pulse.
- step_count: increments by 1 on each step_pulse cycle; the increment is visible the cycle after the pulse. Wrap at all-ones to 0 is silent. RUN-mode cycles are not counted.

Optional Feature:
- Macro: STEP_AUTOREPEAT_EN.
- Defined:
  - In HELD, when the timer reaches HOLD_CYCLES-1, emit step_pulse, clear the timer and enter REPEAT.
  - In REPEAT, emit step_pulse each time the timer reaches REPEAT_CYCLES-1, then clear it.
  - step_btn low in either state returns to IDLE with the timer cleared.
  - Entering RUN mode or halt asserting also returns to IDLE with the timer cleared.
- Undefined: HELD never times out, the REPEAT state and the two timing parameters are unused, and each press yields exactly one pulse.

Decomposition:
- Shared package step_ctrl_pkg holds:
  - the FSM state encoding (IDLE=2'd0, HELD=2'd1, REPEAT=2'd2);
  - the default HOLD_CYCLES/REPEAT_CYCLES constants, so the debouncer and this block share one timing table.
- One sub-module, edge_rise: a registered rising-edge detector with reset-load-current-value behaviour, instantiated for step_btn and mode_btn.

Test Plan (bench parameters HOLD_CYCLES=8, REPEAT_CYCLES=4):
- Step press: reset, then step_btn high for 3 cycles -> step_pulse and cpu_en high exactly 1 cycle, 1 cycle after the press; step_count=1.
- Held through reset: step_btn high during and after reset release -> no pulse; step_count stays 0.
- Mode toggle and halt: mode_btn rise -> run_mode=1 and cpu_en=1 continuously. A step press during RUN -> step_count unchanged. halt=1 for 1 cycle together with a mode rise -> run_mode=0.
- Auto-repeat (with STEP_AUTOREPEAT_EN): step_btn held 20 cycles -> pulses at cycle offsets 1, 9, 13, 17 after the press; step_count=4; release -> IDLE, no further pulses.
- Counter wrap: force 65535 pulses, then one more -> step_count=0.
- Mid-hold reset: rst asserted during REPEAT -> all outputs 0 next cycle; no pulse after rst deasserts while still held.
